// File: rtl/mem_stage_unit_pkg.sv
// Shared encodings for the memory stage: access opcodes and FSM states,
// used by the decoder, the control unit and the memory stage itself.
package mem_stage_unit_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_e;

endpackage

// File: rtl/mem_stage_unit.sv
// Memory stage: turns an enable edge into one load/store handshake with the
// memory, with a request timeout and a sticky per-access error flag.
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              I_enmem,
  input  logic [OP_W-1:0]   I_op,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_wdata,
  output logic [DATA_W-1:0] O_rdata,
  output logic              O_done,
  output logic              O_busy,
  output logic              O_err,
  output logic              O_mem_req,
  output logic              O_mem_we,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic [DATA_W-1:0] O_mem_wdata,
  input  logic              I_mem_ack,
  input  logic [DATA_W-1:0] I_mem_rdata
);

  state_e           state;
  op_e              op_q;
  logic             en_q;
  logic [CNT_W-1:0] cnt;
  logic             start;

  // Only a fresh enable edge seen while idle launches an access.
  assign start = I_enmem && !en_q && (state == IDLE);

  // Single-process FSM; every output is a flop updated with the next state.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state       <= IDLE;
      op_q        <= OP_NONE;
      en_q        <= 1'b0;
      cnt         <= '0;
      O_rdata     <= '0;
      O_done      <= 1'b0;
      O_busy      <= 1'b0;
      O_err       <= 1'b0;
      O_mem_req   <= 1'b0;
      O_mem_we    <= 1'b0;
      O_mem_addr  <= '0;
      O_mem_wdata <= '0;
    end else begin
      en_q      <= I_enmem;
      O_done    <= 1'b0;
      O_mem_req <= 1'b0;
      O_mem_we  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q        <= op_e'(I_op);
            O_mem_addr  <= I_addr;
            O_mem_wdata <= I_wdata;
            O_busy      <= 1'b1;
            O_err       <= 1'b0;
            case (op_e'(I_op))
              OP_NONE: begin
                state  <= DONE;
                O_done <= 1'b1;
              end
              OP_LOAD, OP_STORE: begin
                state     <= REQ;
                cnt       <= '0;
                O_mem_req <= 1'b1;
                O_mem_we  <= (op_e'(I_op) == OP_STORE);
              end
              OP_RSVD: begin
                state  <= ERR;
                O_done <= 1'b1;
                O_err  <= 1'b1;
              end
            endcase
          end
        end
        REQ: begin
          // An ack in the final counted cycle still completes normally.
          if (I_mem_ack) begin
            state  <= DONE;
            O_done <= 1'b1;
            if (op_q == OP_LOAD) O_rdata <= I_mem_rdata;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state  <= ERR;
            cnt    <= cnt + CNT_W'(1);
            O_done <= 1'b1;
            O_err  <= 1'b1;
          end else begin
            cnt       <= cnt + CNT_W'(1);
            O_mem_req <= 1'b1;
            O_mem_we  <= (op_q == OP_STORE);
          end
        end
        DONE, ERR: begin
          state  <= IDLE;
          O_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: directed scenarios plus randomized accesses
// checked against a transaction-level model of request/done/error timing.
module tb_mem_stage_unit;
  import mem_stage_unit_pkg::*;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              enmem;
  logic [1:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              busy;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] model_rdata;
  logic              model_err;

  mem_stage_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .I_clk(clk), .I_reset(rst), .I_enmem(enmem), .I_op(op), .I_addr(addr),
    .I_wdata(wdata), .O_rdata(rdata), .O_done(done), .O_busy(busy), .O_err(err),
    .O_mem_req(mem_req), .O_mem_we(mem_we), .O_mem_addr(mem_addr),
    .O_mem_wdata(mem_wdata), .I_mem_ack(mem_ack), .I_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raises enmem with the given access, then scrambles inputs to prove latching.
  task automatic launch(input logic [1:0] o, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] w);
    enmem = 1'b0;
    step();
    enmem = 1'b1; op = o; addr = a; wdata = w;
    step();
    enmem = 1'b0; op = 2'($urandom); addr = ADDR_W'($urandom); wdata = DATA_W'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; enmem = 1'b0; mem_ack = 1'b0;
    step(); step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0000", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0000", mem_wdata); end
    // Enable already high when reset drops must start an access.
    enmem = 1'b1; op = 2'b00;
    step();
    rst = 1'b0;
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_release_start got=%b exp=1", done); end
    enmem = 1'b0;
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle done=%b busy=%b exp=0/0", done, busy);
    end
    model_rdata = '0; model_err = 1'b0;
  endtask

  task automatic test_load();
    int n_done = 0;
    launch(2'b01, 16'h0040, 16'h0000);
    for (int c = 1; c <= 5; c++) begin
      checks++; if (mem_req !== (c <= 3)) begin errors++; $display("FAIL load_req c=%0d got=%b exp=%b", c, mem_req, c <= 3); end
      if (c <= 3) begin
        checks++; if (mem_addr !== 16'h0040 || mem_we !== 1'b0) begin
          errors++; $display("FAIL load_addr c=%0d got=%h we=%b exp=0040 we=0", c, mem_addr, mem_we);
        end
      end
      if (done) n_done++;
      if (c >= 4) begin
        checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL load_rdata c=%0d got=%h exp=beef", c, rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_err c=%0d got=%b exp=0", c, err); end
      end
      mem_ack   = (c == 3);
      mem_rdata = (c == 3) ? 16'hBEEF : DATA_W'($urandom);
      step();
    end
    mem_ack = 1'b0;
    checks++; if (n_done != 1) begin errors++; $display("FAIL load_done_count got=%0d exp=1", n_done); end
    model_rdata = 16'hBEEF; model_err = 1'b0;
  endtask

  task automatic test_store();
    launch(2'b10, 16'h0012, 16'h1234);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL store_req got req=%b we=%b exp=1/1", mem_req, mem_we);
    end
    checks++; if (mem_addr !== 16'h0012 || mem_wdata !== 16'h1234) begin
      errors++; $display("FAIL store_bus got addr=%h wdata=%h exp=0012/1234", mem_addr, mem_wdata);
    end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL store_early_done got=%b exp=0", done); end
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL store_done got req=%b we=%b done=%b exp=0/0/1", mem_req, mem_we, done);
    end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL store_idle got done=%b busy=%b exp=0/0", done, busy);
    end
    checks++; if (rdata !== model_rdata) begin errors++; $display("FAIL store_rdata_kept got=%h exp=%h", rdata, model_rdata); end
  endtask

  task automatic test_timeout();
    launch(2'b01, DATA_W'($urandom), 16'h0);
    mem_ack = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      checks++; if (mem_req !== (c <= 15)) begin errors++; $display("FAIL tmo_req c=%0d got=%b exp=%b", c, mem_req, c <= 15); end
      checks++; if (done !== (c == 16)) begin errors++; $display("FAIL tmo_done c=%0d got=%b exp=%b", c, done, c == 16); end
      checks++; if (err !== (c >= 16)) begin errors++; $display("FAIL tmo_err c=%0d got=%b exp=%b", c, err, c >= 16); end
      step();
    end
    launch(2'b00, 16'h0, 16'h0);
    checks++; if (err !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL tmo_clear got err=%b done=%b exp=0/1", err, done);
    end
    step();
    model_err = 1'b0;
  endtask

  task automatic test_rsvd_retrigger();
    int n_done = 0;
    int n_req = 0;
    enmem = 1'b0;
    step();
    enmem = 1'b1; op = 2'b11;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) n_done++;
      if (mem_req) n_req++;
      if (i == 0) begin
        checks++; if (err !== 1'b1 || done !== 1'b1) begin
          errors++; $display("FAIL rsvd_first got err=%b done=%b exp=1/1", err, done);
        end
      end
    end
    enmem = 1'b0;
    checks++; if (n_done != 1) begin errors++; $display("FAIL retrigger_done_count got=%0d exp=1", n_done); end
    checks++; if (n_req != 0) begin errors++; $display("FAIL rsvd_req_count got=%0d exp=0", n_req); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rsvd_err_sticky got=%b exp=1", err); end
    model_err = 1'b1;
  endtask

  task automatic test_reset_mid();
    launch(2'b01, 16'h0777, 16'h0);
    mem_ack = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req2 got=%b exp=1", mem_req); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got req=%b busy=%b done=%b exp=0/0/0", mem_req, busy, done);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet got done=%b busy=%b err=%b exp=0/0/0", done, busy, err);
    end
    model_rdata = '0; model_err = 1'b0;
  endtask

  task automatic test_race();
    launch(2'b01, 16'h0100, 16'h0);
    for (int c = 1; c <= 16; c++) begin
      checks++; if (mem_req !== (c <= 15)) begin errors++; $display("FAIL race_req c=%0d got=%b exp=%b", c, mem_req, c <= 15); end
      mem_ack   = (c == 15);
      mem_rdata = 16'hA5A5;
      if (c < 16) step();
    end
    mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 16'hA5A5) begin
      errors++; $display("FAIL race_done got done=%b err=%b rdata=%h exp=1/0/a5a5", done, err, rdata);
    end
    step();
    model_rdata = 16'hA5A5; model_err = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0]        t_op;
    logic [ADDR_W-1:0] t_addr;
    logic [DATA_W-1:0] t_wdata;
    logic [DATA_W-1:0] t_rdata;
    logic [DATA_W-1:0] new_rdata;
    logic              is_mem;
    logic              acked;
    logic              fin_err;
    logic              exp_req;
    int                ack_at;
    int                last_req;
    int                done_cyc;
    for (int t = 0; t < 40; t++) begin
      t_op    = 2'($urandom);
      t_addr  = ADDR_W'($urandom);
      t_wdata = DATA_W'($urandom);
      t_rdata = DATA_W'($urandom);
      ack_at  = $urandom_range(1, 18);
      is_mem    = (t_op == 2'b01) || (t_op == 2'b10);
      acked     = is_mem && (ack_at <= 15);
      last_req  = is_mem ? ((ack_at <= 15) ? ack_at : 15) : 0;
      done_cyc  = last_req + 1;
      fin_err   = (t_op == 2'b11) || (is_mem && !acked);
      new_rdata = (t_op == 2'b01 && acked) ? t_rdata : model_rdata;
      mem_ack = 1'b0;
      launch(t_op, t_addr, t_wdata);
      for (int c = 1; c <= done_cyc + 1; c++) begin
        exp_req = (c <= last_req);
        checks++; if (mem_req !== exp_req) begin errors++; $display("FAIL rnd_req t=%0d c=%0d got=%b exp=%b", t, c, mem_req, exp_req); end
        checks++; if (mem_we !== (exp_req && t_op == 2'b10)) begin
          errors++; $display("FAIL rnd_we t=%0d c=%0d got=%b exp=%b", t, c, mem_we, exp_req && t_op == 2'b10);
        end
        if (exp_req) begin
          checks++; if (mem_addr !== t_addr || mem_wdata !== t_wdata) begin
            errors++; $display("FAIL rnd_bus t=%0d c=%0d got=%h/%h exp=%h/%h", t, c, mem_addr, mem_wdata, t_addr, t_wdata);
          end
        end
        checks++; if (done !== (c == done_cyc)) begin errors++; $display("FAIL rnd_done t=%0d c=%0d got=%b exp=%b", t, c, done, c == done_cyc); end
        checks++; if (busy !== (c <= done_cyc)) begin errors++; $display("FAIL rnd_busy t=%0d c=%0d got=%b exp=%b", t, c, busy, c <= done_cyc); end
        checks++; if (err !== ((c >= done_cyc) ? fin_err : 1'b0)) begin
          errors++; $display("FAIL rnd_err t=%0d c=%0d got=%b exp=%b", t, c, err, (c >= done_cyc) ? fin_err : 1'b0);
        end
        checks++; if (rdata !== ((c >= done_cyc) ? new_rdata : model_rdata)) begin
          errors++; $display("FAIL rnd_rdata t=%0d c=%0d got=%h exp=%h", t, c, rdata, (c >= done_cyc) ? new_rdata : model_rdata);
        end
        // Stray acks outside the request window must be ignored.
        mem_ack   = (c == ack_at) || (c > last_req && $urandom_range(0, 1) == 1);
        mem_rdata = (c == ack_at) ? t_rdata : DATA_W'($urandom);
        step();
      end
      mem_ack = 1'b0;
      model_rdata = new_rdata;
      model_err   = fin_err;
      step();
      checks++; if (err !== model_err) begin errors++; $display("FAIL rnd_err_hold t=%0d got=%b exp=%b", t, err, model_err); end
    end
  endtask

  initial begin
    rst = 1'b1; enmem = 1'b0; op = 2'b00; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_rdata = '0; model_err = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_rsvd_retrigger();
    test_reset_mid();
    test_race();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
